imem_dmem_port_arbiter: RTL and testbench
=========================================

Name: imem_dmem_port_arbiter

Overview:
- Shares one synchronous single-port word memory between the instruction-fetch requester (IF) and the load/store requester (D).
- Sits between the fetch stage, the memory stage and the unified program/data memory.
- At most one access is issued per cycle. Read data returns exactly one cycle after grant, tagged to the requester that issued it.
- D has fixed priority over IF (the older instruction wins), with an optional anti-starvation guard.

Parameters:
- ADDR_W, 13, word-address width of the memory port (depth 2^ADDR_W words)
- MEM_WORDS, 8184, populated words; word addresses at or above this are out of range
- MAX_D_STREAK, 4, consecutive D grants with IF waiting before IF is forced through (guard only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch accepted this cycle
- if_valid  out  1  if_rdata valid (cycle after if_gnt)
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_wmask  in  4  byte enables for stores (sb/sh/sw lanes)
- d_addr  in  32  data byte address; bits [1:0] ignored (lane select via d_wmask)
- d_wdata  in  32  store data, pre-shifted to lanes
- d_gnt  out  1  data access accepted this cycle
- d_valid  out  1  load data / store ack valid (cycle after d_gnt)
- d_rdata  out  32  loaded word
- mem_en  out  1  memory access strobe
- mem_we  out  4  per-byte write enable (0000 for reads)
- mem_addr  out  ADDR_W  word address = granted addr[ADDR_W+1:2]
- mem_wdata  out  32  write data
- mem_rdata  in  32  read word, valid the cycle after mem_en

Behaviour:
- Reset values: if_valid=0, d_valid=0, owner register=OWN_NONE, streak counter=0. While rst=1: if_gnt=0, d_gnt=0, mem_en=0, mem_we=0000.
- Grant is combinational from the requests and the streak state:
  - d_req alone -> D
  - if_req alone -> IF
  - both -> D, except with the guard when streak==MAX_D_STREAK -> IF
- Issued access: mem_en=1 only if the granted word address < MEM_WORDS. mem_we = d_wmask if D and d_we, else 0000.
- Owner register: one flop pair records {OWN_NONE, OWN_IF, OWN_D, plus out-of-range flag} for the access issued this cycle.
- Next cycle:
  - OWN_IF -> if_valid=1
  - OWN_D -> d_valid=1 (also for stores, as the ack)
  - if_rdata and d_rdata both carry mem_rdata, or 32'h0 if the access was out of range.
- Pipelined: a new grant may issue in the same cycle a previous response returns. Throughput is 1 access/cycle; latency is 1 cycle.
- Out-of-range: the grant and valid still occur; no memory write; rdata=0.
- No request: owner becomes OWN_NONE, so both valids are 0 next cycle.
- Reset asserted mid-operation: the pending response is dropped. No valid pulse occurs after reset release until a new grant.

Optional Feature:
- Macro: ARB_FETCH_STARVE_GUARD_EN.
- Defined:
  - The streak counter (width clog2(MAX_D_STREAK+1)) increments on each D grant while if_req=1, saturating at MAX_D_STREAK.
  - It clears on any IF grant or any cycle with if_req=0.
  - At saturation with both requesting, IF wins.
- Undefined: no counter; strict D priority; IF may starve indefinitely.

Decomposition:
- Shared package/header holds:
  - owner encoding constants OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2
  - WMASK_NONE=4'b0000, WMASK_WORD=4'b1111
  - MEM_WORDS default
- One natural sub-module, arb_prio_pick: the two-way picker plus the guarded streak counter. Top level holds the mux, range check and owner/response register.

Test Plan:
- Fetch only: if_req=1, if_addr=0x8, mem word 2=0x00fff0b7 -> if_gnt same cycle; next cycle if_valid=1, if_rdata=0x00fff0b7, d_valid=0.
- Store then load: d_we=1, d_wmask=0011, d_addr=0x4, d_wdata=0x0000feef -> mem_we=0011, mem_addr=1, d_valid next cycle. Then load 0x4 -> d_rdata[15:0]=0xfeef.
- Contention, guard off: if_req=d_req=1 for 10 cycles -> d_gnt every cycle, if_gnt never.
- Contention, guard on (MAX_D_STREAK=4): pattern is d_gnt x4, if_gnt x1, repeating; if_valid pulses 1 cycle after each if_gnt.
- Out of range: d_addr=0x8000 (word 8192) load -> mem_en=0, d_valid=1 next cycle, d_rdata=0.
- Reset mid-access: d_gnt at cycle N, rst pulses at N+0.5 -> d_valid stays 0 at N+1. Both valids stay 0 after release until a new grant.

Source files
------------

// File: rtl/imem_dmem_port_arbiter_pkg.sv
// Shared constants and types for the IF/D single-port memory arbiter.
// Optional fetch anti-starvation guard: ARB_FETCH_STARVE_GUARD_EN.
package imem_dmem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 13;
  localparam int unsigned MEM_WORDS_DEF    = 8184;
  localparam int unsigned MAX_D_STREAK_DEF = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] WMASK_NONE = 4'b0000;
  localparam logic [3:0] WMASK_WORD = 4'b1111;

  // Owner of the access issued last cycle, plus its out-of-range flag
  typedef struct packed {
    logic       oor;
    logic [1:0] own;
  } owner_t;

endpackage

// File: rtl/imem_dmem_port_arbiter_arb_prio_pick.sv
// Two-way IF/D grant picker; D has priority unless the streak guard
// (ARB_FETCH_STARVE_GUARD_EN) forces a waiting fetch through.
module arb_prio_pick
  import imem_dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_gnt_c,
  output logic d_gnt_c
);

`ifdef ARB_FETCH_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(MAX_D_STREAK + 1);

  logic [CNT_W-1:0] streak_q, streak_d;
  logic             force_if_c;

  assign force_if_c = (streak_q == CNT_W'(MAX_D_STREAK));

  // Streak counts D wins while IF waits; cleared when IF gets in or stops asking
  always_comb begin
    d_gnt_c  = d_req_i && !(if_req_i && force_if_c);
    if_gnt_c = if_req_i && !d_gnt_c;
    streak_d = streak_q;
    if (!if_req_i || if_gnt_c) begin
      streak_d = '0;
    end else if (d_gnt_c && !force_if_c) begin
      streak_d = streak_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  logic unused_pick;

  assign unused_pick = ^{clk, rst, 32'(MAX_D_STREAK)};

  always_comb begin
    d_gnt_c  = d_req_i;
    if_gnt_c = if_req_i && !d_req_i;
  end
`endif

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one synchronous single-port word memory between fetch (IF) and load/store (D).
// Build with ARB_FETCH_STARVE_GUARD_EN to bound how long IF can be starved by D.
module imem_dmem_port_arbiter
  import imem_dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned MEM_WORDS    = MEM_WORDS_DEF,
  parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic        if_gnt_c, d_gnt_c, any_gnt_c, in_range_c;
  logic [29:0] sel_waddr_c;
  owner_t      owner_q, owner_d;
  logic        unused_lane_bits;

  assign unused_lane_bits = ^{if_addr[1:0], d_addr[1:0]};

  // Requests are masked during reset so nothing is granted or strobed
  arb_prio_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .if_req_i (if_req && !rst),
    .d_req_i  (d_req && !rst),
    .if_gnt_c (if_gnt_c),
    .d_gnt_c  (d_gnt_c)
  );

  // Full word address is range-checked so aliases above the port width are caught
  always_comb begin
    sel_waddr_c = d_gnt_c ? d_addr[31:2] : if_addr[31:2];
    any_gnt_c   = if_gnt_c || d_gnt_c;
    in_range_c  = (sel_waddr_c < 30'(MEM_WORDS));

    if_gnt    = if_gnt_c;
    d_gnt     = d_gnt_c;
    mem_en    = any_gnt_c && in_range_c;
    mem_addr  = sel_waddr_c[ADDR_W-1:0];
    mem_wdata = d_wdata;
    mem_we    = WMASK_NONE;
    if (any_gnt_c && in_range_c && d_gnt_c && d_we) begin
      mem_we = d_wmask;
    end

    owner_d.own = OWN_NONE;
    owner_d.oor = any_gnt_c && !in_range_c;
    if (d_gnt_c) begin
      owner_d.own = OWN_D;
    end else if (if_gnt_c) begin
      owner_d.own = OWN_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= '{oor: 1'b0, own: OWN_NONE};
    end else begin
      owner_q <= owner_d;
    end
  end

  // Response is tagged by the owner recorded at grant time
  always_comb begin
    if_valid = (owner_q.own == OWN_IF);
    d_valid  = (owner_q.own == OWN_D);
    if_rdata = owner_q.oor ? 32'h0 : mem_rdata;
    d_rdata  = owner_q.oor ? 32'h0 : mem_rdata;
  end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed scoreboard bench for imem_dmem_port_arbiter with a behavioural memory.
module tb_imem_dmem_port_arbiter;
  import imem_dmem_port_arbiter_pkg::*;

  localparam int unsigned AW    = 13;
  localparam int unsigned WORDS = 8184;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt, if_valid;
  logic [31:0]   if_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_wmask;
  logic [31:0]   d_addr, d_wdata;
  logic          d_gnt, d_valid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  typedef struct packed {
    logic        iv;
    logic        dv;
    logic        ck;
    logic [31:0] rdata;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] mem     [0:8191];
  logic [31:0] ref_mem [0:8191];
  int          total  = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  imem_dmem_port_arbiter #(
    .ADDR_W(AW), .MEM_WORDS(WORDS), .MAX_D_STREAK(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h00fff0b7;
    return (32'(i) * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous single-port memory: read data valid the cycle after mem_en
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One issue cycle: drive, check grant/memory strobe, then check the tagged response
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                      input logic [3:0] dm, input logic [31:0] da, input logic [31:0] dwd,
                      input logic ei, input logic ed);
    logic [29:0] wa;
    logic        inr;
    logic [3:0]  ewe;
    resp_t       r;
    @(negedge clk);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_wmask = dm; d_addr = da; d_wdata = dwd;
    #1;
    chk("if_gnt", 32'(if_gnt), 32'(ei));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    wa  = ed ? da[31:2] : ia[31:2];
    inr = (ei || ed) && (wa < 30'(WORDS));
    ewe = (inr && ed && dwe) ? dm : WMASK_NONE;
    chk("mem_en", 32'(mem_en), 32'(inr));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    if (inr) chk("mem_addr", 32'(mem_addr), 32'(wa[AW-1:0]));
    r.iv    = ei;
    r.dv    = ed;
    r.ck    = ei || (ed && !dwe);
    r.rdata = inr ? ref_mem[wa[AW-1:0]] : 32'h0;
    if (inr && ed && dwe)
      for (int b = 0; b < 4; b++)
        if (dm[b]) ref_mem[wa[AW-1:0]][8*b +: 8] = dwd[8*b +: 8];
    sb.push_back(r);
    @(posedge clk);
    #1;
    r = sb.pop_front();
    chk("if_valid", 32'(if_valid), 32'(r.iv));
    chk("d_valid", 32'(d_valid), 32'(r.dv));
    if (r.ck) chk(r.iv ? "if_rdata" : "d_rdata", r.iv ? if_rdata : d_rdata, r.rdata);
  endtask

  initial begin
    logic ed;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b1;
    d_wmask = WMASK_WORD; d_addr = 32'h4; d_wdata = 32'h0;

    // Reset holds off all grants and strobes
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'(WMASK_NONE));
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;

    step(1'b1, 32'h8, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h4, 32'h0000feef, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h4, 32'h0, 1'b0, 1'b1);
    chk("store_lanes", {16'h0, ref_mem[1][15:0]}, 32'h0000feef);

    // Sustained contention: back-to-back issues with responses overlapping grants
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_FETCH_STARVE_GUARD_EN
      ed = ((i % 5) != 4);
`else
      ed = 1'b1;
`endif
      step(1'b1, 32'h8, 1'b1, 1'b0, 4'b0000, 32'h4, 32'h0, !ed, ed);
    end

    step(1'b0, 32'h8, 1'b0, 1'b0, 4'b0000, 32'h4, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h8000, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, WMASK_WORD, 32'h8000, 32'hdeadbeef, 1'b0, 1'b1);
    step(1'b1, 32'h8000, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, WMASK_WORD, 32'h7FDC, 32'hcafe1234, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h7FDC, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h7FE0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0000FFFC, 32'h0, 1'b0, 1'b1);

    // Reset arriving while a grant is being issued drops it
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    #1;
    chk("pre_rst_d_gnt", 32'(d_gnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'(WMASK_NONE));
    @(posedge clk);
    #1;
    chk("mid_rst_d_valid", 32'(d_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_if_valid", 32'(if_valid), 32'd0);
      chk("post_rst_d_valid", 32'(d_valid), 32'd0);
    end

    // Reset arriving while a response is on the bus drops that response
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    @(posedge clk);
    #1;
    chk("resp_d_valid", 32'(d_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("resp_dropped", 32'(d_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("resp_no_valid", 32'(d_valid), 32'd0);

    step(1'b1, 32'h8, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
